// File: rtl/report_frame_parser.sv
// report_frame_parser: decodes UART loop/error report records into registered fields
module report_frame_parser #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_data_valid,
  output logic                  loop_record_valid,
  output logic [7:0]            loop_error_count,
  output logic [15:0]           loop_count,
  output logic                  error_record_valid,
  output logic [7:0]            error_state,
  output logic [ADDR_WIDTH-1:0] error_address,
  output logic [DATA_WIDTH-1:0] expected_data,
  output logic [DATA_WIDTH-1:0] actual_data,
  output logic                  frame_error,
  output logic [7:0]            frame_error_count
);
  localparam logic [7:0] NA_LAST = 8'((ADDR_WIDTH + 7) / 8 - 1);
  localparam logic [7:0] ND_LAST = 8'((DATA_WIDTH + 7) / 8 - 1);
  typedef enum logic [3:0] {IDLE, L_ERRCNT, L_LOOPCNT, E_STATE, E_ADDR, E_EXP, E_ACT, CR, LF} state_t;
  state_t state, state_n;
  logic [7:0] cnt;
  logic is_err, commit, ferr;
  logic [7:0] w_errcnt, w_state;
  logic [15:0] w_loopcnt;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_exp, w_act;
  // next state, commit and frame-error decode; only a strobe moves the FSM
  always_comb begin
    state_n = state;
    commit = 1'b0;
    ferr = 1'b0;
    if (rx_data_valid)
      case (state)
        IDLE:      state_n = rx_data == 8'h4C ? L_ERRCNT : rx_data == 8'h45 ? E_STATE : IDLE;
        L_ERRCNT:  state_n = L_LOOPCNT;
        L_LOOPCNT: state_n = cnt == 8'd1 ? CR : L_LOOPCNT;
        E_STATE:   state_n = E_ADDR;
        E_ADDR:    state_n = cnt == NA_LAST ? E_EXP : E_ADDR;
        E_EXP:     state_n = cnt == ND_LAST ? E_ACT : E_EXP;
        E_ACT:     state_n = cnt == ND_LAST ? CR : E_ACT;
        CR: begin
          state_n = rx_data == 8'h0D ? LF : IDLE;
          ferr = rx_data != 8'h0D;
        end
        LF: begin
          state_n = IDLE;
          commit = rx_data == 8'h0A;
          ferr = rx_data != 8'h0A;
        end
        default:   state_n = IDLE;
      endcase
  end
  // state register; byte lane counter restarts whenever the state changes
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= 8'd0;
    end else if (rx_data_valid) begin
      state <= state_n;
      cnt <= state_n != state ? 8'd0 : cnt + 8'd1;
    end
  // working registers: each field byte lands in its lane, bits past the field width are dropped
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      is_err <= 1'b0;
      w_errcnt <= 8'd0;
      w_loopcnt <= 16'd0;
      w_state <= 8'd0;
      w_addr <= '0;
      w_exp <= '0;
      w_act <= '0;
    end else if (rx_data_valid)
      case (state)
        IDLE:      is_err <= rx_data == 8'h45;
        L_ERRCNT:  w_errcnt <= rx_data;
        L_LOOPCNT: if (cnt[0]) w_loopcnt[15:8] <= rx_data; else w_loopcnt[7:0] <= rx_data;
        E_STATE:   w_state <= rx_data;
        E_ADDR:    for (int j = 0; j < ADDR_WIDTH; j++) if (cnt == 8'(j / 8)) w_addr[j] <= rx_data[j % 8];
        E_EXP:     for (int j = 0; j < DATA_WIDTH; j++) if (cnt == 8'(j / 8)) w_exp[j] <= rx_data[j % 8];
        E_ACT:     for (int j = 0; j < DATA_WIDTH; j++) if (cnt == 8'(j / 8)) w_act[j] <= rx_data[j % 8];
        default: ;
      endcase
  // visible outputs: copied from working registers on commit, pulses last one cycle
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      loop_record_valid <= 1'b0;
      loop_error_count <= 8'd0;
      loop_count <= 16'd0;
      error_record_valid <= 1'b0;
      error_state <= 8'd0;
      error_address <= '0;
      expected_data <= '0;
      actual_data <= '0;
      frame_error <= 1'b0;
      frame_error_count <= 8'd0;
    end else begin
      loop_record_valid <= commit & ~is_err;
      error_record_valid <= commit & is_err;
      frame_error <= ferr;
      if (commit & ~is_err) begin
        loop_error_count <= w_errcnt;
        loop_count <= w_loopcnt;
      end
      if (commit & is_err) begin
        error_state <= w_state;
        error_address <= w_addr;
        expected_data <= w_exp;
        actual_data <= w_act;
      end
      if (ferr) frame_error_count <= frame_error_count + {7'd0, frame_error_count != 8'hFF};
    end
endmodule

// File: tb/tb_report_frame_parser.sv
// tb_report_frame_parser: random and directed record streams against a buffer-based reference model
module tb_report_frame_parser;
  logic clk = 1'b0, rst = 1'b0, rx_data_valid = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic lrv0, erv0, fe0, lrv1, erv1, fe1;
  logic [7:0] lec0, es0, fc0, lec1, es1, fc1;
  logic [15:0] lc0, lc1;
  logic [5:0] ea0;
  logic [0:0] ed0, ad0;
  logic [15:0] ea1;
  logic [7:0] ed1, ad1;
  int vectors = 0, miscompares = 0;
  int na[2] = '{1, 2};
  int nd[2] = '{1, 1};
  int aw[2] = '{6, 16};
  int dw[2] = '{1, 8};
  logic [7:0] mb[2][32];
  int ml[2];
  logic [31:0] m_lv[2], m_lec[2], m_lc[2], m_ev[2], m_es[2], m_ea[2], m_ed[2], m_ad[2], m_fe[2], m_fc[2];
  always #5 clk = ~clk;
  report_frame_parser dut0 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .loop_record_valid(lrv0), .loop_error_count(lec0), .loop_count(lc0),
    .error_record_valid(erv0), .error_state(es0), .error_address(ea0),
    .expected_data(ed0), .actual_data(ad0), .frame_error(fe0), .frame_error_count(fc0)
  );
  report_frame_parser #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) dut1 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .loop_record_valid(lrv1), .loop_error_count(lec1), .loop_count(lc1),
    .error_record_valid(erv1), .error_state(es1), .error_address(ea1),
    .expected_data(ed1), .actual_data(ad1), .frame_error(fe1), .frame_error_count(fc1)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] field(input int k, input int off, input int n, input int w);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < n; i++) v |= 32'(mb[k][off + i]) << (8 * i);
    return v & ((32'd1 << w) - 32'd1);
  endfunction
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ml[k] = 0;
      m_lv[k] = 0; m_lec[k] = 0; m_lc[k] = 0; m_ev[k] = 0; m_es[k] = 0;
      m_ea[k] = 0; m_ed[k] = 0; m_ad[k] = 0; m_fe[k] = 0; m_fc[k] = 0;
    end
  endtask
  task automatic model_step(input int k, input logic [7:0] b);
    int total;
    logic bad;
    bad = 1'b0;
    m_lv[k] = 0; m_ev[k] = 0; m_fe[k] = 0;
    if (ml[k] == 0) begin
      if (b == 8'h4C || b == 8'h45) begin
        mb[k][0] = b;
        ml[k] = 1;
      end
    end else begin
      mb[k][ml[k]] = b;
      ml[k]++;
      total = mb[k][0] == 8'h4C ? 6 : 4 + na[k] + 2 * nd[k];
      if (ml[k] == total - 1 && b != 8'h0D) bad = 1'b1;
      else if (ml[k] == total) begin
        if (b != 8'h0A) bad = 1'b1;
        else if (mb[k][0] == 8'h4C) begin
          m_lv[k] = 1; m_lec[k] = 32'(mb[k][1]); m_lc[k] = field(k, 2, 2, 16);
        end else begin
          m_ev[k] = 1; m_es[k] = 32'(mb[k][1]);
          m_ea[k] = field(k, 2, na[k], aw[k]);
          m_ed[k] = field(k, 2 + na[k], nd[k], dw[k]);
          m_ad[k] = field(k, 2 + na[k] + nd[k], nd[k], dw[k]);
        end
        ml[k] = 0;
      end
      if (bad) begin
        m_fe[k] = 1;
        if (m_fc[k] < 255) m_fc[k]++;
        ml[k] = 0;
      end
    end
  endtask
  task automatic check_all();
    chk("lv0", 32'(lrv0), m_lv[0]); chk("lec0", 32'(lec0), m_lec[0]); chk("lc0", 32'(lc0), m_lc[0]);
    chk("ev0", 32'(erv0), m_ev[0]); chk("es0", 32'(es0), m_es[0]); chk("ea0", 32'(ea0), m_ea[0]);
    chk("ed0", 32'(ed0), m_ed[0]); chk("ad0", 32'(ad0), m_ad[0]); chk("fe0", 32'(fe0), m_fe[0]);
    chk("fc0", 32'(fc0), m_fc[0]);
    chk("lv1", 32'(lrv1), m_lv[1]); chk("lec1", 32'(lec1), m_lec[1]); chk("lc1", 32'(lc1), m_lc[1]);
    chk("ev1", 32'(erv1), m_ev[1]); chk("es1", 32'(es1), m_es[1]); chk("ea1", 32'(ea1), m_ea[1]);
    chk("ed1", 32'(ed1), m_ed[1]); chk("ad1", 32'(ad1), m_ad[1]); chk("fe1", 32'(fe1), m_fe[1]);
    chk("fc1", 32'(fc1), m_fc[1]);
  endtask
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_data_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_data_valid = 1'b0;
    model_step(0, b);
    model_step(1, b);
    check_all();
  endtask
  task automatic send_bytes(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) send(v[8 * (n - 1 - i) +: 8]);
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        m_lv[k] = 0; m_ev[k] = 0; m_fe[k] = 0;
      end
      check_all();
    end
  endtask
  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rx_data = 8'h4C;
    rx_data_valid = 1'b1;
    model_reset();
    #1;
    check_all();
    repeat (n) @(posedge clk);
    #1;
    rx_data_valid = 1'b0;
    rst = 1'b1;
    check_all();
  endtask
  initial begin
    logic [7:0] r[16];
    int n, kind;
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    send_bytes(64'h4C0334120D0A, 6);
    chk("r033_lv", 32'(lrv0), 1); chk("r033_lec", 32'(lec0), 'h03); chk("r033_lc", 32'(lc0), 'h1234);
    idle(1);
    chk("r033_lv_once", 32'(lrv0), 0);
    send_bytes(64'h45072A01000D0A, 7);
    chk("r034_ev", 32'(erv0), 1); chk("r034_es", 32'(es0), 'h07); chk("r034_ea", 32'(ea0), 'h2A);
    chk("r034_ed", 32'(ed0), 1); chk("r034_ad", 32'(ad0), 0);
    send_bytes(64'h4C0001000D41, 6);
    chk("r035_fe", 32'(fe0), 1); chk("r035_fc", 32'(fc0), 1); chk("r035_lv", 32'(lrv0), 0);
    chk("r035_lc", 32'(lc0), 'h1234);
    do_reset(2);
    send_bytes(64'h00FF0D, 3);
    send_bytes(64'h4C0334120D0A, 6);
    chk("r036_lv", 32'(lrv0), 1); chk("r036_lc", 32'(lc0), 'h1234); chk("r036_fc", 32'(fc0), 0);
    do_reset(1);
    send_bytes(64'h4507, 2);
    do_reset(3);
    send_bytes(64'h2A01000D0A, 5);
    chk("r037_ev", 32'(erv0), 0); chk("r037_fe", 32'(fe0), 0); chk("r037_es", 32'(es0), 0);
    chk("r037_ea", 32'(ea0), 0); chk("r037_fc", 32'(fc0), 0);
    do_reset(1);
    send_bytes(64'h4501CDAB5AA50D0A, 8);
    chk("r038_ev", 32'(erv1), 1); chk("r038_ea", 32'(ea1), 'hABCD);
    chk("r038_ed", 32'(ed1), 'h5A); chk("r038_ad", 32'(ad1), 'hA5);
    repeat (260) send_bytes(64'h4C00000041, 5);
    chk("sat_fc0", 32'(fc0), 255); chk("sat_fc1", 32'(fc1), 255);
    do_reset(1);
    repeat (300) begin
      kind = $urandom_range(0, 4);
      for (int i = 0; i < 16; i++) r[i] = 8'($urandom);
      n = kind == 0 ? 6 : kind == 1 ? 7 : kind == 2 ? 8 : kind == 3 ? 1 : $urandom_range(1, 10);
      if (kind == 0) r[0] = 8'h4C;
      if (kind == 1 || kind == 2) r[0] = 8'h45;
      if (kind <= 2 && $urandom_range(0, 7) != 0) begin
        r[n - 2] = 8'h0D;
        r[n - 1] = 8'h0A;
      end
      for (int i = 0; i < n; i++) begin
        send(r[i]);
        if ($urandom_range(0, 5) == 0) idle(1);
      end
      if ($urandom_range(0, 49) == 0) do_reset($urandom_range(1, 3));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
